// File: rtl/regfile_ctrl_top.sv
// Register file + ALU controller driven by board buttons/switches; led shows read port 1.
// Latency: raw btnc rise to register commit is 5 edges plus the debounce window.
// No backpressure: button events outside IDLE are dropped; optional macro REGFILE_DEBOUNCE_EN.
module regfile_ctrl_top #(
    parameter int BUS_WIDTH       = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btnc,
    input  logic        btnl,
    input  logic        btnu,
    input  logic        btnd,
    input  logic [15:0] sw,
    output logic [15:0] led
);

    localparam int NREG = 1 << ADDR_WIDTH;

`ifdef REGFILE_DEBOUNCE_EN
    localparam bit DB_ON = 1'b1;
`else
    localparam bit DB_ON = 1'b0;
`endif
    // Stability window actually used; zero means the conditioned level is the synced level.
    localparam int DB = DB_ON ? DEBOUNCE_CYCLES : 0;

    // Bit order for the button vectors: {btnd, btnu, btnl, btnc}
    logic [3:0] sync1, sync2;
    logic [2:0] cond, cond_q, evt;
    logic       btnd_s;

    // Two-flop synchronizers for all raw buttons
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {btnd, btnu, btnl, btnc};
            sync2 <= sync1;
        end
    end

    assign btnd_s = sync2[3];

    generate
        if (DB > 0) begin : g_db
            localparam int CW = (DB > 1) ? $clog2(DB) : 1;
            logic [CW-1:0] cnt [3];

            // Level follows the synced input only after DB consecutive disagreeing cycles
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cond <= '0;
                    for (int i = 0; i < 3; i++) cnt[i] <= '0;
                end else begin
                    for (int i = 0; i < 3; i++) begin
                        if (sync2[i] == cond[i]) begin
                            cnt[i] <= '0;
                        end else if (cnt[i] == CW'(DB - 1)) begin
                            cond[i] <= sync2[i];
                            cnt[i]  <= '0;
                        end else begin
                            cnt[i] <= cnt[i] + CW'(1);
                        end
                    end
                end
            end
        end else begin : g_nodb
            assign cond = sync2[2:0];
        end
    endgenerate

    // Previous conditioned level for rising-edge event detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cond_q <= '0;
        else        cond_q <= cond;
    end

    assign evt = cond & ~cond_q;

    // Address register: clear beats load when both events land together
    logic [ADDR_WIDTH-1:0] raddr1, raddr2, waddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr1 <= '0;
            raddr2 <= '0;
            waddr  <= '0;
        end else if (evt[2]) begin
            raddr1 <= '0;
            raddr2 <= '0;
            waddr  <= '0;
        end else if (evt[1]) begin
            raddr1 <= sw[ADDR_WIDTH-1:0];
            raddr2 <= sw[5 +: ADDR_WIDTH];
            waddr  <= sw[10 +: ADDR_WIDTH];
        end
    end

    // Register file with combinational reads; entry 0 is never written
    logic [BUS_WIDTH-1:0]  regs [NREG];
    logic [BUS_WIDTH-1:0]  rdata1, rdata2;

    assign rdata1 = (raddr1 == '0) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : regs[raddr2];

    // ALU on the two read ports, op taken from the live switches
    logic [BUS_WIDTH-1:0] alu;
    logic [4:0]           shamt;

    assign shamt = rdata2[4:0];

    // ALU operation decode; unlisted codes fall back to ADD
    always_comb begin
        alu = rdata1 + rdata2;
        case (sw[3:0])
            4'b0000: alu = rdata1 & rdata2;
            4'b0001: alu = rdata1 | rdata2;
            4'b0010: alu = rdata1 + rdata2;
            4'b0110: alu = rdata1 - rdata2;
            4'b0111: alu = {{(BUS_WIDTH-1){1'b0}}, ($signed(rdata1) < $signed(rdata2))};
            4'b1001: alu = rdata1 >> shamt;
            4'b1010: alu = rdata1 << shamt;
            4'b1011: alu = $signed(rdata1) >>> shamt;
            4'b1101: alu = rdata1 ^ rdata2;
            default: alu = rdata1 + rdata2;
        endcase
    end

    // Immediate mode: sw[15] is both the mode flag and the sign of the 15-bit value
    logic [31:0]          imm_full;
    logic [BUS_WIDTH-1:0] wdata;

    assign imm_full = {{17{sw[15]}}, sw[14:0]};
    assign wdata    = sw[15] ? imm_full[BUS_WIDTH-1:0] : alu;

    // Write sequencer
    typedef enum logic [1:0] {IDLE, CAPTURE, WRITE, HOLD} state_t;
    state_t state, nxt;

    logic [BUS_WIDTH-1:0]  lat_data;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic                  do_latch, do_write;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= nxt;
    end

    // Next state and datapath strobes; HOLD waits for the button to be released
    always_comb begin
        nxt      = state;
        do_latch = 1'b0;
        do_write = 1'b0;
        case (state)
            IDLE:    if (evt[0]) nxt = CAPTURE;
            CAPTURE: begin
                do_latch = 1'b1;
                nxt      = WRITE;
            end
            WRITE:   begin
                do_write = (lat_addr != '0);
                nxt      = HOLD;
            end
            HOLD:    if (!cond[0]) nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Snapshot of data and target so later address/switch changes cannot disturb the write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_data <= '0;
            lat_addr <= '0;
        end else if (do_latch) begin
            lat_data <= wdata;
            lat_addr <= waddr;
        end
    end

    // Register array update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (do_write) begin
            regs[lat_addr] <= lat_data;
        end
    end

    // Display: low half when btnd held, else upper half zero-extended
    logic [31:0] r1_ext;

    assign r1_ext = 32'(rdata1);
    assign led    = btnd_s ? r1_ext[15:0] : r1_ext[31:16];

endmodule

// File: tb/tb_regfile_ctrl_top.sv
// Randomized bench with an event-scheduled behavioural model of the controller.
// Model updates are placed at the edges the timing rules predict; led is compared every cycle.
// Stimulus is applied 2 time units after each rising edge, checking happens on falling edges.
module tb_regfile_ctrl_top;

`ifdef REGFILE_DEBOUNCE_EN
    localparam int D = 16;
`else
    localparam int D = 0;
`endif
    localparam int MINP = (D > 0) ? D : 1;
    localparam int H    = (D > 0) ? D + 4 : 2;

    logic        clk, rst_n, btnc, btnl, btnu, btnd;
    logic [15:0] sw, led;

    regfile_ctrl_top #(.BUS_WIDTH(32), .ADDR_WIDTH(5), .DEBOUNCE_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .btnc(btnc), .btnl(btnl), .btnu(btnu),
        .btnd(btnd), .sw(sw), .led(led)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Model state
    typedef struct {int at; int kind; logic [15:0] val;} ev_t;
    ev_t         q[$];
    logic [31:0] m_regs [32];
    logic [4:0]  m_ra1, m_ra2, m_wa, m_lat_a;
    logic [31:0] m_lat_d;
    logic        m_btnd;

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        case (op)
            4'd0:    return a & b;
            4'd1:    return a | b;
            4'd6:    return a - b;
            4'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:    return a >> b[4:0];
            4'd10:   return a << b[4:0];
            4'd11:   return $signed(a) >>> b[4:0];
            4'd13:   return a ^ b;
            default: return a + b;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_ra1 = '0; m_ra2 = '0; m_wa = '0; m_lat_a = '0; m_lat_d = '0; m_btnd = 1'b0;
        q.delete();
    endtask

    task automatic apply_ev(input ev_t e);
        case (e.kind)
            0: begin
                if (sw[15]) m_lat_d = {17'h1FFFF, sw[14:0]};
                else        m_lat_d = alu_ref(m_regs[m_ra1], m_regs[m_ra2], sw[3:0]);
                m_lat_a = m_wa;
            end
            1: if (m_lat_a != 0) m_regs[m_lat_a] = m_lat_d;
            2: begin m_ra1 = sw[4:0]; m_ra2 = sw[9:5]; m_wa = sw[14:10]; end
            3: begin m_ra1 = '0; m_ra2 = '0; m_wa = '0; end
            default: m_btnd = e.val[0];
        endcase
    endtask

    // Edge counter and scheduled model updates (capture, write, load, clear, display select)
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (rst_n) begin
            for (int k = 0; k < 5; k++)
                foreach (q[i]) if (q[i].at == cyc && q[i].kind == k) apply_ev(q[i]);
            for (int i = q.size() - 1; i >= 0; i--) if (q[i].at <= cyc) q.delete(i);
        end
    end

    // Per-cycle comparison of led against the model
    always @(negedge clk) begin
        logic [31:0] r;
        logic [15:0] exp_led;
        if (rst_n) begin
            r       = m_regs[m_ra1];
            exp_led = m_btnd ? r[15:0] : r[31:16];
            checks++;
            if (led !== exp_led) begin
                errors++;
                if (errors < 20) $display("FAIL led_cycle%0d: got %h want %h", cyc, led, exp_led);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    function automatic ev_t mk(input int at, input int kind, input logic [15:0] val);
        ev_t e;
        e.at = at; e.kind = kind; e.val = val;
        return e;
    endfunction

    // Clean button pulses starting at offsets (-1 = unused); raw rise after edge e0+t gives
    // address update at e0+t+3+D, capture at e0+t+4+D and commit at e0+t+5+D.
    task automatic drive(input logic [15:0] sw0, input int c_st, input int c_len,
                         input int l_st, input int l_len, input int u_st, input int u_len,
                         input int sw_t, input logic [15:0] sw1);
        int e0, last, n;
        last = 0;
        if (c_st >= 0 && c_st + c_len > last) last = c_st + c_len;
        if (l_st >= 0 && l_st + l_len > last) last = l_st + l_len;
        if (u_st >= 0 && u_st + u_len > last) last = u_st + u_len;
        n = last + 10 + 2 * D;
        @(posedge clk); #2;
        e0 = cyc;
        if (c_st >= 0 && c_len >= MINP) begin
            q.push_back(mk(e0 + c_st + 4 + D, 0, 16'h0));
            q.push_back(mk(e0 + c_st + 5 + D, 1, 16'h0));
        end
        if (l_st >= 0 && l_len >= MINP) q.push_back(mk(e0 + l_st + 3 + D, 2, 16'h0));
        if (u_st >= 0 && u_len >= MINP) q.push_back(mk(e0 + u_st + 3 + D, 3, 16'h0));
        for (int t = 0; t < n; t++) begin
            if (t == 0) sw = sw0;
            if (t == sw_t) sw = sw1;
            btnc = (c_st >= 0 && t >= c_st && t < c_st + c_len);
            btnl = (l_st >= 0 && t >= l_st && t < l_st + l_len);
            btnu = (u_st >= 0 && t >= u_st && t < u_st + u_len);
            @(posedge clk); #2;
        end
    endtask

    task automatic set_btnd(input logic v);
        @(posedge clk); #2;
        btnd = v;
        q.push_back(mk(cyc + 2, 4, {15'h0, v}));
        repeat (3) @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] wa);
        drive({1'b0, wa, ra2, ra1}, -1, 0, 0, H, -1, 0, -1, 16'h0);
    endtask

    task automatic alu_wr(input logic [4:0] ra1, input logic [4:0] ra2, input logic [4:0] wa, input logic [3:0] op);
        load(ra1, ra2, wa);
        drive({12'h0, op}, 0, H, -1, 0, -1, 0, -1, 16'h0);
    endtask

    task automatic imm_wr(input logic [4:0] wa, input logic [14:0] v);
        load(5'd0, 5'd0, wa);
        drive({1'b1, v}, 0, H, -1, 0, -1, 0, -1, 16'h0);
    endtask

    task automatic show(input logic [4:0] ra);
        load(ra, 5'd0, 5'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e0;
        rst_n = 1'b0; btnc = 0; btnl = 0; btnu = 0; btnd = 0; sw = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_led", {16'h0, led}, 32'h0);
        @(posedge clk); #2;
        rst_n = 1'b1;

        // Immediate write to r3, then display it
        drive(16'h8C05, -1, 0, 0, H, -1, 0, -1, 16'h0);
        drive(16'h8C05, 0, H, -1, 0, -1, 0, -1, 16'h0);
        drive(16'h0003, -1, 0, 0, H, -1, 0, -1, 16'h0);
        @(negedge clk);
        chk("imm_led_upper", {16'h0, led}, 32'h0000FFFF);
        chk("model_r3", m_regs[3], 32'hFFFF8C05);
        set_btnd(1'b1);
        @(negedge clk);
        chk("imm_led_lower", {16'h0, led}, 32'h00008C05);

        // Build r1=7, r2=5 from a negative immediate via SLT and ADDs
        imm_wr(5'd9, 15'h0001);
        alu_wr(5'd9, 5'd0, 5'd10, 4'd7);
        alu_wr(5'd10, 5'd10, 5'd11, 4'd2);
        alu_wr(5'd11, 5'd11, 5'd12, 4'd2);
        alu_wr(5'd12, 5'd11, 5'd1, 4'd2);
        alu_wr(5'd1, 5'd10, 5'd1, 4'd2);
        alu_wr(5'd12, 5'd10, 5'd2, 4'd2);
        chk("model_r1", m_regs[1], 32'd7);
        chk("model_r2", m_regs[2], 32'd5);
        alu_wr(5'd1, 5'd2, 5'd4, 4'd6);
        show(5'd4);
        @(negedge clk);
        chk("sub_r4", {16'h0, led}, 32'd2);
        imm_wr(5'd1, 15'h7FFF);
        alu_wr(5'd1, 5'd2, 5'd4, 4'd7);
        show(5'd4);
        @(negedge clk);
        chk("slt_r4", {16'h0, led}, 32'd1);

        // Register 0 ignores writes
        imm_wr(5'd0, 15'h1234);
        show(5'd0);
        @(negedge clk);
        chk("r0_lower", {16'h0, led}, 32'h0);
        set_btnd(1'b0);
        @(negedge clk);
        chk("r0_upper", {16'h0, led}, 32'h0);
        set_btnd(1'b1);

        // Held btnc produces a single increment of r12 (4 -> 5)
        load(5'd12, 5'd10, 5'd12);
        drive(16'h0002, 0, 100, -1, 0, -1, 0, -1, 16'h0);
        @(negedge clk);
        chk("held_once", {16'h0, led}, 32'd5);

        // Load and clear in the same cycle: clear wins
        drive({1'b0, 5'd12, 5'd10, 5'd12}, -1, 0, 0, H, 0, H, -1, 16'h0);
        @(negedge clk);
        chk("clear_wins", {16'h0, led}, 32'd0);

        // Address reload right after capture must not redirect the pending write
        load(5'd12, 5'd10, 5'd12);
        drive(16'h0002, 0, H, 2, H, -1, 0, 4 + D, {1'b0, 5'd4, 5'd0, 5'd4});
        @(negedge clk);
        chk("redirect_view", {16'h0, led}, 32'd1);
        show(5'd12);
        @(negedge clk);
        chk("pending_kept", {16'h0, led}, 32'd6);

        // Short and long btnc pulses on r12 += r10
        load(5'd12, 5'd10, 5'd12);
        drive(16'h0002, 0, 10, -1, 0, -1, 0, -1, 16'h0);
        @(negedge clk);
        chk("pulse10", {16'h0, led}, (D > 10) ? 32'd6 : 32'd7);
        drive(16'h0002, 0, 20, -1, 0, -1, 0, -1, 16'h0);
        @(negedge clk);
        chk("pulse20", {16'h0, led}, (D > 10) ? 32'd7 : 32'd8);

        // Randomized operations
        for (int it = 0; it < 30; it++) begin
            case ($urandom_range(0, 5))
                0: imm_wr(5'($urandom_range(1, 31)), 15'($urandom));
                1: alu_wr(5'($urandom), 5'($urandom), 5'($urandom_range(1, 31)), 4'($urandom));
                2: show(5'($urandom));
                3: set_btnd(1'($urandom));
                4: drive(16'($urandom), -1, 0, -1, 0, 0, H, -1, 16'h0);
                default: drive({1'b0, 15'($urandom)}, 0, $urandom_range(1, MINP + 3), -1, 0, -1, 0, -1, 16'h0);
            endcase
        end

        // Reset during CAPTURE aborts the write to r20
        set_btnd(1'b0);
        load(5'd20, 5'd0, 5'd20);
        @(posedge clk); #2;
        e0 = cyc;
        sw = 16'hFFFF;
        btnc = 1'b1;
        while (cyc < e0 + 3 + D) begin
            @(posedge clk); #2;
        end
        rst_n = 1'b0;
        btnc  = 1'b0;
        model_reset();
        @(negedge clk);
        chk("reset_mid_led", {16'h0, led}, 32'h0);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drive(16'h0000, -1, 0, -1, 0, -1, 0, -1, 16'h0);
        show(5'd20);
        @(negedge clk);
        chk("aborted_upper", {16'h0, led}, 32'h0);
        set_btnd(1'b1);
        @(negedge clk);
        chk("aborted_lower", {16'h0, led}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl_top.md
REGFILE_CTRL_TOP -- requirements
Module: regfile_ctrl_top

Interface
REQ-001 Parameter BUS_WIDTH, default 32, SHALL set the register and ALU data width; legal range 8..32.
REQ-002 Parameter ADDR_WIDTH, default 5, SHALL set the register count to 2**ADDR_WIDTH; legal range 1..5.
REQ-003 Parameter DEBOUNCE_CYCLES, default 16, SHALL set the debounce stability window D; legal range >= 1.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state changes on the rising edge.
REQ-005 Port rst_n, input, 1, SHALL be the asynchronous active-low reset.
REQ-006 Port btnc, input, 1, SHALL be the raw write-request button.
REQ-007 Port btnl, input, 1, SHALL be the raw address-load button.
REQ-008 Port btnu, input, 1, SHALL be the raw address-clear button.
REQ-009 Port btnd, input, 1, SHALL be the raw display-half select level.
REQ-010 Port sw, input, 16, SHALL carry the address fields, ALU op and immediate data.
REQ-011 Port led, output, 16, SHALL show the selected half of read data 1.

Function
REQ-012 Each button SHALL pass a two-flop synchronizer; btnc/btnl/btnu SHALL produce a one-cycle event on the rising edge of their conditioned level.
REQ-013 Address register SHALL hold raddr1=sw[4:0], raddr2=sw[9:5], waddr=sw[14:10], each truncated to the low ADDR_WIDTH bits.
REQ-014 A btnu event SHALL clear the address register; a btnl event SHALL load it from sw. Simultaneous events: clear wins.
REQ-015 Register file SHALL read asynchronously on both ports; register 0 SHALL read 0 and ignore writes.
REQ-016 ALU op sw[3:0]: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 signed SLT (result 1/0), 1001 SRL, 1010 SLL, 1011 SRA (shift amount op2[4:0]), 1101 XOR; all others ADD. Arithmetic wraps modulo 2**BUS_WIDTH.
REQ-017 Write data SHALL be sw[14:0] sign-extended to BUS_WIDTH when sw[15]=1 (truncated if BUS_WIDTH<15), else ALU result of rdata1 op rdata2.
REQ-018 Write FSM states IDLE, CAPTURE, WRITE, HOLD: IDLE->CAPTURE on btnc event; CAPTURE latches write data and waddr; CAPTURE->WRITE unconditionally; WRITE commits the latched data to the latched address at its closing edge; WRITE->HOLD; HOLD->IDLE when conditioned btnc is low.
REQ-019 btnc events outside IDLE SHALL be ignored; address changes after CAPTURE SHALL NOT alter the pending write.
REQ-020 Raw btnc rising before edge 1 SHALL produce the register write at rising edge 5+D (D=0 when debounce is compiled out).
REQ-021 led SHALL be rdata1[15:0] when synchronized btnd=1, else rdata1[BUS_WIDTH-1:16] zero-extended (all 0 when BUS_WIDTH<=16).

Reset
REQ-022 rst_n low SHALL asynchronously clear all registers, address register, synchronizers, debounce state and FSM (to IDLE); led SHALL read 0.
REQ-023 Reset asserted mid-operation SHALL abort any pending write with no register modified after assertion.

Configuration
REQ-024 Macro REGFILE_DEBOUNCE_EN defined: conditioned level SHALL toggle only after the synchronized input differs from it for D consecutive cycles; any agreement cycle restarts the count.
REQ-025 Macro REGFILE_DEBOUNCE_EN undefined: conditioned level SHALL equal the synchronizer output; DEBOUNCE_CYCLES is ignored.

Verification
REQ-026 Immediate write: sw=0x8C05 (waddr=3, imm), btnl then btnc, then sw=0x0003, btnl -> register 3 = 0xFFFF8C05 sign-extended, led=0xFFFF (btnd=0), 0x8C05 (btnd=1).
REQ-027 ALU writeback: r1=7, r2=5, sw selects waddr=4, raddr1=1, raddr2=2, op 0110 -> r4=2; op 0111 with r1=-1 -> 1.
REQ-028 Register 0: write 0x1234 to waddr=0 -> reading r0 yields 0.
REQ-029 Debounce (macro defined, D=16): btnc pulse of 10 cycles -> no write; pulse of 20 cycles -> exactly one write at edge 21.
REQ-030 Held/repeated btnc: btnc held 100 cycles -> one write; btnl and btnu events same cycle -> address register 0.
REQ-031 Reset mid-write: rst_n low during CAPTURE -> target register remains 0, FSM IDLE, led 0.
